fft_frame_loader: RTL
=====================

# fft_frame_loader

Front-end writer for the radix-2 FFT datapath. Accepts a serial stream of WIDTH-bit samples over a valid/ready handshake and writes each sample into a SAMPLES-entry frame in bit-reversed index order. It presents completed frames as the parallel sample array that the FFT stage logic reads. Two ping-pong banks allow one frame to be filled while the previous one is held stable for the FFT stages.

## Interface
- SAMPLES, 4, frame length; power of two, >= 2
- WIDTH, 32, sample word width; opaque packed complex word, never interpreted here
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  WIDTH  sample word
- in_valid  in  1  in_data valid this cycle
- in_last  in  1  marks the final word of a frame; qualified by in_valid
- in_ready  out  1  loader can accept a word this cycle
- frame_out  out  WIDTH x SAMPLES (unpacked [SAMPLES-1:0])  presented frame, bit-reversed order
- frame_valid  out  1  frame_out holds a complete frame
- frame_ack  in  1  consumer releases the presented frame; ignored when frame_valid=0
- frame_err  out  1  sticky framing error; cleared only by rst

## Operation
- State: wr_cnt (log2 SAMPLES bits), fill_bank, out_bank, full[1:0], frame_err, two banks of SAMPLES x WIDTH registers.
- Accept = in_valid && in_ready. On accept, write in_data to bank[fill_bank][bitrev(wr_cnt)] and increment wr_cnt.
- Frame completion happens on an accept with wr_cnt == SAMPLES-1:
  - wr_cnt wraps to 0, full[fill_bank] <= 1, fill_bank toggles.
  - If in_last=0 on that word, the frame still completes and frame_err <= 1.
- Early in_last (accept with in_last=1 and wr_cnt < SAMPLES-1):
  - The partial frame is discarded and wr_cnt <= 0.
  - full and fill_bank are unchanged, frame_err <= 1.
  - Stale words left in that bank are overwritten by the next fill.
- in_ready = !full[fill_bank]. It depends on registers only and never on in_valid.
- frame_valid = full[out_bank]. frame_out = bank[out_bank].
- frame_ack && frame_valid: full[out_bank] <= 0 and out_bank toggles.
- Simultaneous frame completion and ack: both take effect in the same cycle.
  - This is always legal because the two events target different banks, or the same bank only when both banks are full. That last case is impossible, since in_ready would be 0.
- Bank contents are write-only from the stream side. A presented bank is never written.

## Timing
- Reset values:
  - wr_cnt=0, fill_bank=0, out_bank=0, full=00, frame_err=0, all bank words 0.
  - Outputs: in_ready=1, frame_valid=0, frame_out all zeros.
- Latency: final word accepted at edge N gives frame_valid=1 and the new frame_out from edge N onward, i.e. usable in cycle N+1.
- frame_out is stable for the whole time frame_valid=1 and the same bank is presented.
- Ack at edge M:
  - If the other bank is full, frame_valid stays 1 and frame_out switches to the next frame at edge M.
  - Otherwise frame_valid drops at edge M.
- Throughput: one word per cycle sustained when the consumer acks within SAMPLES cycles of each frame_valid.
- Backpressure: when both banks are full, in_ready=0 until the edge after an ack.
- Reset mid-frame: the partial frame is lost. No output glitches beyond the async clear.

## Structure
- Shared package fft_pkg holds:
  - localparam LOG2_SAMPLES = $clog2(SAMPLES)
  - function bit_reverse(index, bits), reused by twiddle and stage indexing
  - sample word typedef sample_t (logic [WIDTH-1:0])
- One sub-module, fft_sample_bank:
  - SAMPLES x WIDTH register array with async clear, a single indexed write port (we, waddr, wdata) and a full parallel read.
  - Instantiated twice. The top level muxes frame_out by out_bank.

## Test plan
- SAMPLES=4, send 10,11,12,13 (in_last on 13), frame_ack held 0 -> frame_valid=1 the cycle after 13; frame_out[0..3]=10,12,11,13; frame_err=0.
- Two back-to-back frames (20..23, then 30..33), no ack -> second frame accepted, in_ready=0 after 33; a third frame is stalled. Ack once -> frame_out=20,22,21,23 becomes 30,32,31,33 with frame_valid held 1, and in_ready=1 on the next cycle.
- in_last on the second word (40,41), then 50..53 -> 40,41 discarded, frame_err=1 sticky; frame_out=50,52,51,53.
- 60..63 with no in_last -> frame completes normally with data 60,62,61,63; frame_err=1.
- Assert rst asynchronously after two words of a frame -> outputs immediately return to reset values (frame_valid=0, in_ready=1, frame_out zeros). A following 70..73 yields 70,72,71,73.
- Continuous stream of 8 frames with frame_ack pulsed each time frame_valid rises -> in_ready never deasserts; every frame is bit-reversed correctly; no frames lost or duplicated.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizing, sample word type and bit-reversal helper.
package fft_pkg;

  localparam int unsigned DEF_SAMPLES  = 4;
  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned LOG2_SAMPLES = $clog2(DEF_SAMPLES);

  typedef logic [DEF_WIDTH-1:0] sample_t;

  // Reverses the low 'bits' bits of index; upper result bits are zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] index, input int unsigned bits);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < bits; i++) begin
      r[i] = index[bits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sample_bank.sv
// One frame of sample registers: single indexed write port, full parallel read.
module fft_sample_bank #(
  parameter int unsigned SAMPLES = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AW      = $clog2(SAMPLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_data [SAMPLES-1:0]
);

  logic [WIDTH-1:0] r_mem [SAMPLES-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SAMPLES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_data = r_mem;

endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-frame loader: writes samples bit-reversed into ping-pong banks and
// presents completed frames in order to the FFT stages.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int unsigned SAMPLES = DEF_SAMPLES,
  parameter int unsigned WIDTH   = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] frame_out [SAMPLES-1:0],
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic             frame_err
);

  localparam int unsigned   AW       = $clog2(SAMPLES);
  localparam logic [AW-1:0] LAST_IDX = AW'(SAMPLES - 1);

  logic [AW-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic          r_fill_bank, w_fill_bank_nxt;
  logic          r_out_bank, w_out_bank_nxt;
  logic [1:0]    r_full, w_full_nxt;
  logic          r_frame_err, w_frame_err_nxt;

  logic             w_accept;
  logic             w_ack;
  logic             w_last_slot;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_bank0 [SAMPLES-1:0];
  logic [WIDTH-1:0] w_bank1 [SAMPLES-1:0];

  assign in_ready    = !r_full[r_fill_bank];
  assign frame_valid = r_full[r_out_bank];
  assign frame_err   = r_frame_err;

  assign w_accept    = in_valid && in_ready;
  assign w_ack       = frame_ack && frame_valid;
  assign w_last_slot = (r_wr_cnt == LAST_IDX);
  assign w_waddr     = AW'(bit_reverse(32'(r_wr_cnt), AW));

  // Completion and ack never touch the same bank: a full fill bank blocks accept.
  always_comb begin
    w_wr_cnt_nxt    = r_wr_cnt;
    w_fill_bank_nxt = r_fill_bank;
    w_out_bank_nxt  = r_out_bank;
    w_full_nxt      = r_full;
    w_frame_err_nxt = r_frame_err;
    if (w_accept) begin
      if (w_last_slot) begin
        w_wr_cnt_nxt              = '0;
        w_full_nxt[r_fill_bank]   = 1'b1;
        w_fill_bank_nxt           = !r_fill_bank;
        if (!in_last) begin
          w_frame_err_nxt = 1'b1;
        end
      end else if (in_last) begin
        w_wr_cnt_nxt    = '0;
        w_frame_err_nxt = 1'b1;
      end else begin
        w_wr_cnt_nxt = r_wr_cnt + 1'b1;
      end
    end
    if (w_ack) begin
      w_full_nxt[r_out_bank] = 1'b0;
      w_out_bank_nxt         = !r_out_bank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt    <= '0;
      r_fill_bank <= 1'b0;
      r_out_bank  <= 1'b0;
      r_full      <= 2'b00;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_fill_bank <= w_fill_bank_nxt;
      r_out_bank  <= w_out_bank_nxt;
      r_full      <= w_full_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  fft_sample_bank #(
    .SAMPLES (SAMPLES),
    .WIDTH   (WIDTH),
    .AW      (AW)
  ) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_accept && !r_fill_bank),
    .i_waddr (w_waddr),
    .i_wdata (in_data),
    .o_data  (w_bank0)
  );

  fft_sample_bank #(
    .SAMPLES (SAMPLES),
    .WIDTH   (WIDTH),
    .AW      (AW)
  ) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_accept && r_fill_bank),
    .i_waddr (w_waddr),
    .i_wdata (in_data),
    .o_data  (w_bank1)
  );

  always_comb begin
    for (int unsigned i = 0; i < SAMPLES; i++) begin
      frame_out[i] = r_out_bank ? w_bank1[i] : w_bank0[i];
    end
  end

endmodule
